rank_sorter: RTL and testbench

//  Sits directly downstream of the PageRank ant block. Consumes the packed page-value bus (vals) on a start pulse.

---
 rtl/rank_sorter.sv | 138 +++++++++++++
 tb/tb_rank_sorter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rank_sorter.sv
// rtl/rank_sorter.sv - odd-even transposition sorter for page values, descending, stable on ties
module rank_sorter #(
   parameter int N     = 16,
   parameter int WIDTH = 16,
   parameter int IDW   = 4
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_start,
   input  logic [N*WIDTH-1:0] i_vals,
   output logic               o_busy,
   output logic               o_done,
   output logic [N*WIDTH-1:0] o_sorted_vals,
   output logic [N*IDW-1:0]   o_sorted_ids,
   output logic [IDW-1:0]     o_top_id
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SORT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // N phases are enough for odd-even transposition to fully sort N entries
   localparam logic [IDW:0] LAST_PHASE = (IDW+1)'(N-1);

   state_t               r_state;
   state_t               w_state_nxt;
   logic [IDW:0]         r_cnt;
   logic [WIDTH-1:0]     r_work_val [N];
   logic [IDW-1:0]       r_work_id  [N];
   logic [WIDTH-1:0]     w_phase_val [N];
   logic [IDW-1:0]       w_phase_id  [N];
   logic [N*WIDTH-1:0]   r_sorted_vals;
   logic [N*IDW-1:0]     r_sorted_ids;
   logic                 w_last_phase;

   assign w_last_phase  = (r_cnt == LAST_PHASE);
   assign o_sorted_vals = r_sorted_vals;
   assign o_sorted_ids  = r_sorted_ids;
   assign o_top_id      = r_sorted_ids[IDW-1:0];

   // State register; reset abandons any sort in progress
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and status outputs; start is only honoured in IDLE
   always_comb begin
      w_state_nxt = r_state;
      o_busy      = 1'b0;
      o_done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_state_nxt = S_SORT;
            end
         end
         S_SORT: begin
            o_busy = 1'b1;
            if (w_last_phase) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            o_busy      = 1'b1;
            o_done      = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // One compare/exchange phase: pairs start on even slots for even cnt, odd slots for odd cnt
   always_comb begin
      for (int y = 0; y < N; y++) begin
         w_phase_val[y] = r_work_val[y];
         w_phase_id[y]  = r_work_id[y];
      end
      for (int a = 0; a < N - 1; a++) begin
         // strict compare keeps equal values in their current (ascending id) order
         if ((a[0] == r_cnt[0]) && (r_work_val[a+1] > r_work_val[a])) begin
            w_phase_val[a]   = r_work_val[a+1];
            w_phase_val[a+1] = r_work_val[a];
            w_phase_id[a]    = r_work_id[a+1];
            w_phase_id[a+1]  = r_work_id[a];
         end
      end
   end

   // Work arrays, phase counter and result registers
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_cnt         <= '0;
         r_sorted_vals <= '0;
         r_sorted_ids  <= '0;
         for (int y = 0; y < N; y++) begin
            r_work_val[y] <= '0;
            r_work_id[y]  <= '0;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_cnt <= '0;
                  for (int y = 0; y < N; y++) begin
                     r_work_val[y] <= i_vals[y*WIDTH +: WIDTH];
                     r_work_id[y]  <= IDW'(y);
                  end
               end
            end
            S_SORT: begin
               r_cnt <= r_cnt + (IDW+1)'(1);
               for (int y = 0; y < N; y++) begin
                  r_work_val[y] <= w_phase_val[y];
                  r_work_id[y]  <= w_phase_id[y];
               end
               // results are published only on the way into DONE
               if (w_last_phase) begin
                  for (int y = 0; y < N; y++) begin
                     r_sorted_vals[y*WIDTH +: WIDTH] <= w_phase_val[y];
                     r_sorted_ids[y*IDW +: IDW]      <= w_phase_id[y];
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rank_sorter.sv
// tb/tb_rank_sorter.sv - directed self-checking bench for rank_sorter
module tb_rank_sorter;

   localparam int N   = 16;
   localparam int W   = 16;
   localparam int IDW = 4;

   logic             clk;
   logic             reset;
   logic             start;
   logic [N*W-1:0]   vals;
   logic             busy;
   logic             done;
   logic [N*W-1:0]   sorted_vals;
   logic [N*IDW-1:0] sorted_ids;
   logic [IDW-1:0]   top_id;

   int checks;
   int failures;

   rank_sorter #(.N(N), .WIDTH(W), .IDW(IDW)) dut (
      .i_clk         (clk),
      .i_reset       (reset),
      .i_start       (start),
      .i_vals        (vals),
      .o_busy        (busy),
      .o_done        (done),
      .o_sorted_vals (sorted_vals),
      .o_sorted_ids  (sorted_ids),
      .o_top_id      (top_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse start for edge E0, then watch 24 edges; returns edge index of first done and pulse count
   task automatic run_sort(input logic [N*W-1:0] v, output int lat, output int pulses);
      lat    = 0;
      pulses = 0;
      vals   = v;
      start  = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 1; k <= 24; k++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) begin
            pulses++;
            if (lat == 0) lat = k;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      start = 1'b0;
      vals  = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (sorted_vals !== '0) begin failures++; $display("FAIL reset_vals got=%h exp=0", sorted_vals); end
      checks++; if (sorted_ids !== '0) begin failures++; $display("FAIL reset_ids got=%h exp=0", sorted_ids); end
      checks++; if (top_id !== '0) begin failures++; $display("FAIL reset_top got=%0d exp=0", top_id); end
      reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_ascending();
      logic [N*W-1:0]   v;
      logic [N*W-1:0]   ev;
      logic [N*IDW-1:0] ei;
      int lat, pulses;
      for (int y = 0; y < N; y++) begin
         v[y*W +: W]    = 16'(y * 256);
         ev[y*W +: W]   = 16'((15 - y) * 256);
         ei[y*IDW +: IDW] = 4'(15 - y);
      end
      run_sort(v, lat, pulses);
      checks++; if (lat != 16) begin failures++; $display("FAIL asc_latency got=%0d exp=16", lat); end
      checks++; if (pulses != 1) begin failures++; $display("FAIL asc_pulses got=%0d exp=1", pulses); end
      checks++; if (sorted_vals[W-1:0] !== 16'h0F00) begin failures++; $display("FAIL asc_slot0 got=%h exp=0f00", sorted_vals[W-1:0]); end
      checks++; if (sorted_vals !== ev) begin failures++; $display("FAIL asc_vals got=%h exp=%h", sorted_vals, ev); end
      checks++; if (sorted_ids !== ei) begin failures++; $display("FAIL asc_ids got=%h exp=%h", sorted_ids, ei); end
      checks++; if (top_id !== 4'd15) begin failures++; $display("FAIL asc_top got=%0d exp=15", top_id); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL asc_idle_busy got=%b exp=0", busy); end
   endtask

   task automatic test_equal();
      logic [N*W-1:0]   v;
      logic [N*IDW-1:0] ei;
      int lat, pulses;
      for (int y = 0; y < N; y++) begin
         v[y*W +: W]      = 16'h1000;
         ei[y*IDW +: IDW] = 4'(y);
      end
      run_sort(v, lat, pulses);
      checks++; if (lat != 16) begin failures++; $display("FAIL eq_latency got=%0d exp=16", lat); end
      checks++; if (sorted_ids !== ei) begin failures++; $display("FAIL eq_ids got=%h exp=%h", sorted_ids, ei); end
      checks++; if (sorted_vals !== v) begin failures++; $display("FAIL eq_vals got=%h exp=%h", sorted_vals, v); end
      checks++; if (top_id !== 4'd0) begin failures++; $display("FAIL eq_top got=%0d exp=0", top_id); end
   endtask

   task automatic test_mixed();
      logic [N*W-1:0]   v;
      logic [N*IDW-1:0] ei;
      int lat, pulses;
      int s;
      for (int y = 0; y < N; y++) v[y*W +: W] = 16'h0001;
      v[3*W +: W] = 16'hFFFF;
      v[9*W +: W] = 16'hFFFF;
      ei[0 +: IDW]   = 4'd3;
      ei[IDW +: IDW] = 4'd9;
      s = 2;
      for (int y = 0; y < N; y++) begin
         if (y != 3 && y != 9) begin
            ei[s*IDW +: IDW] = 4'(y);
            s++;
         end
      end
      run_sort(v, lat, pulses);
      checks++; if (sorted_ids[IDW-1:0] !== 4'd3) begin failures++; $display("FAIL mix_slot0_id got=%0d exp=3", sorted_ids[IDW-1:0]); end
      checks++; if (sorted_ids[IDW +: IDW] !== 4'd9) begin failures++; $display("FAIL mix_slot1_id got=%0d exp=9", sorted_ids[IDW +: IDW]); end
      checks++; if (sorted_ids[15*IDW +: IDW] !== 4'd15) begin failures++; $display("FAIL mix_slot15_id got=%0d exp=15", sorted_ids[15*IDW +: IDW]); end
      checks++; if (top_id !== 4'd3) begin failures++; $display("FAIL mix_top got=%0d exp=3", top_id); end
      checks++; if (sorted_ids !== ei) begin failures++; $display("FAIL mix_ids got=%h exp=%h", sorted_ids, ei); end
      checks++; if (sorted_vals[2*W-1:0] !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mix_top_vals got=%h exp=ffffffff", sorted_vals[2*W-1:0]); end
      checks++; if (sorted_vals[2*W +: W] !== 16'h0001) begin failures++; $display("FAIL mix_slot2_val got=%h exp=0001", sorted_vals[2*W +: W]); end
   endtask

   task automatic test_start_while_busy();
      logic [N*W-1:0]   va;
      logic [N*W-1:0]   vb;
      logic [N*W-1:0]   ev;
      logic [N*IDW-1:0] ei;
      logic [N*IDW-1:0] prev_ids;
      int lat, pulses;
      for (int y = 0; y < N; y++) begin
         va[y*W +: W] = 16'((((y * 5) % 16) * 256) + 16'h0012);
         vb[y*W +: W] = 16'(y * 3);
      end
      for (int s = 0; s < N; s++) begin
         ev[s*W +: W] = 16'(((15 - s) * 256) + 16'h0012);
         for (int y = 0; y < N; y++) begin
            if (((y * 5) % 16) == (15 - s)) ei[s*IDW +: IDW] = 4'(y);
         end
      end
      prev_ids = sorted_ids;
      lat    = 0;
      pulses = 0;
      vals   = va;
      start  = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 1; k <= 24; k++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) begin
            pulses++;
            if (lat == 0) lat = k;
         end
         if (k == 4) begin
            checks++; if (sorted_ids !== prev_ids) begin failures++; $display("FAIL hold_during_sort got=%h exp=%h", sorted_ids, prev_ids); end
            vals  = vb;
            start = 1'b1;
         end
         if (k == 5) start = 1'b0;
      end
      checks++; if (pulses != 1) begin failures++; $display("FAIL busy_pulses got=%0d exp=1", pulses); end
      checks++; if (lat != 16) begin failures++; $display("FAIL busy_latency got=%0d exp=16", lat); end
      checks++; if (sorted_vals !== ev) begin failures++; $display("FAIL busy_vals got=%h exp=%h", sorted_vals, ev); end
      checks++; if (sorted_ids !== ei) begin failures++; $display("FAIL busy_ids got=%h exp=%h", sorted_ids, ei); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_idle got=%b exp=0", busy); end
   endtask

   task automatic test_reset_mid_sort();
      logic [N*W-1:0] v;
      int lat, pulses;
      int late;
      for (int y = 0; y < N; y++) v[y*W +: W] = 16'(y * 256);
      vals  = v;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
      @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL mid_done got=%b exp=0", done); end
      checks++; if (sorted_vals !== '0) begin failures++; $display("FAIL mid_vals got=%h exp=0", sorted_vals); end
      checks++; if (sorted_ids !== '0 || top_id !== '0) begin failures++; $display("FAIL mid_ids got=%h top=%0d exp=0", sorted_ids, top_id); end
      reset = 1'b1;
      late  = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) late++;
      end
      checks++; if (late != 0) begin failures++; $display("FAIL mid_no_done got=%0d exp=0", late); end
      run_sort(v, lat, pulses);
      checks++; if (lat != 16 || pulses != 1) begin failures++; $display("FAIL mid_restart lat=%0d pulses=%0d exp=16/1", lat, pulses); end
      checks++; if (top_id !== 4'd15) begin failures++; $display("FAIL mid_restart_top got=%0d exp=15", top_id); end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b0;
      start    = 1'b0;
      vals     = '0;
      test_reset();
      test_ascending();
      test_equal();
      test_mixed();
      test_start_while_busy();
      test_reset_mid_sort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
